lhn_cam_cache_ctrl: RTL and testbench
=====================================

// Module: lhn_cam_cache_ctrl
// PURPOSE
//  Sequencer for the 2-way, 8-set tag CAM (9-bit tags, 4-bit {set,way} CAM address). Accepts CPU lookups.
//  Reads both ways of the indexed set through the CAM read port and resolves hit/miss.
//  On a miss: picks a victim, fetches the block from memory over a req/ack handshake, writes the new tag into the CAM.
//  Holds valid bits and per-set LRU bits internally; the CAM stores tags only.
// PARAMETERS
//  TAG_W   9   tag width; CAM data width
//  SET_W   3   set index width (8 sets)
//  WORD_W  3   word-in-block offset width (8 words/block)
// PORTS
//  clk         in   1                  rising-edge clock
//  rst_n       in   1                  reset, synchronous, active-low
//  req_valid   in   1                  CPU lookup request
//  req_addr    in   TAG_W+SET_W+WORD_W {tag[14:6], set[5:3], word[2:0]}
//  req_ready   out  1                  high only in IDLE with no flush pending
//  flush       in   1                  one-cycle pulse: invalidate all lines
//  resp_valid  out  1                  one-cycle pulse, lookup complete
//  resp_hit    out  1                  1 = hit, 0 = miss (filled); valid with resp_valid
//  resp_way    out  1                  way holding the block; valid with resp_valid
//  cam_rd_n    out  1                  CAM read enable, active-low
//  cam_we_n    out  1                  CAM write enable, active-low
//  cam_addrs   out  4                  {set, way}
//  cam_din     out  TAG_W              tag written on fill
//  cam_dout    in   TAG_W              CAM read data (combinational from cam_addrs)
//  mem_req     out  1                  block fetch request
//  mem_addr    out  TAG_W+SET_W        block address {tag, set}
//  mem_ack     in   1                  fetch complete
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE.
//   Outputs: req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, cam_rd_n=1, cam_we_n=1, cam_addrs=0, cam_din=0, mem_req=0, mem_addr=0.
//   All valid and LRU bits cleared. Reset mid-operation aborts at once; mem_req drops at that edge.
//  Handshake: request taken on an edge with req_valid & req_ready; req_addr latched there.
//  States: IDLE -> RD0 -> RD1 -> CMP -> {RESP | FILL -> TWR -> RESP} -> IDLE.
//  RD0: cam_rd_n=0, cam_addrs={set,0}; cam_dout latched as t0 at end of cycle.
//  RD1: same for way 1, latched as t1.
//  CMP: hitN = valid[set][N] & (tN==tag). Both hit -> way 0 wins. Any hit -> RESP; else -> FILL.
//  Victim: way0 if invalid; else way1 if invalid; else lru[set] (lru = way to replace next).
//  FILL: mem_req=1, mem_addr={tag,set}, held stable until mem_ack; mem_ack -> TWR. No timeout.
//  TWR: one cycle, cam_we_n=0, cam_addrs={set,victim}, cam_din=tag; valid[set][victim] set at edge.
//  RESP: resp_valid=1 with resp_hit/resp_way; lru[set] <= ~resp_way; -> IDLE.
//  Latency: accept cycle = 0; hit resp_valid in cycle 4; miss resp_valid 2 cycles after the mem_ack cycle.
//  cam_rd_n/cam_we_n high outside RD0/RD1/TWR; never both low.
//  mem_ack outside FILL ignored.
//  flush: in IDLE clears all valid+lru at that edge and takes priority over a simultaneous req.
//   While busy: held pending, applied on the IDLE cycle after RESP; req_ready=0 during that cycle.
// CONFIGURATION
//  LHN_CAM_CTRL_STATS_EN defined: adds outputs hit_cnt[15:0], miss_cnt[15:0].
//   Incremented at each RESP edge by resp_hit; saturate at 16'hFFFF; cleared by reset only (not flush).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, req addr 0x0A5F (tag 0x029, set 3) -> miss; mem_req, mem_addr 0x14B;
//    ack -> TWR writes cam_addrs 0x6 din 0x029; resp hit=0 way=0.
//  2 Repeat 0x0A5F -> resp_valid cycle 4, hit=1 way=0, mem_req never asserted.
//  3 Set 3: fill tags 0x029, 0x033, then 0x040 -> victim way0 (lru);
//    hit 0x033 then miss 0x051 -> victim way0 (lru[3] cleared by the hit on way1).
//  4 flush asserted during FILL -> line still filled and resp sent; next IDLE cycle req_ready=0;
//    re-request 0x0A5F -> miss.
//  5 rst_n low while mem_req=1 -> mem_req=0 after edge, req_ready=1, prior hits now miss.
//  6 STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2; mem_ack pulse in IDLE -> no state change.

Source files
------------

// File: rtl/lhn_cam_cache_ctrl_if.sv
// Bus bundle for lhn_cam_cache_ctrl: CPU lookup/response, flush, tag CAM port and memory fetch.
// master = the controller, slave = the surrounding CPU/CAM/memory side.
interface lhn_cam_cache_ctrl_if #(
    parameter int unsigned TAG_W  = 9,
    parameter int unsigned SET_W  = 3,
    parameter int unsigned WORD_W = 3
);
    logic                            req_valid;
    logic [TAG_W+SET_W+WORD_W-1:0]   req_addr;
    logic                            req_ready;
    logic                            flush;
    logic                            resp_valid;
    logic                            resp_hit;
    logic                            resp_way;
    logic                            cam_rd_n;
    logic                            cam_we_n;
    logic [SET_W:0]                  cam_addrs;
    logic [TAG_W-1:0]                cam_din;
    logic [TAG_W-1:0]                cam_dout;
    logic                            mem_req;
    logic [TAG_W+SET_W-1:0]          mem_addr;
    logic                            mem_ack;

    modport master (
        input  req_valid, req_addr, flush, cam_dout, mem_ack,
        output req_ready, resp_valid, resp_hit, resp_way,
               cam_rd_n, cam_we_n, cam_addrs, cam_din, mem_req, mem_addr
    );

    modport slave (
        output req_valid, req_addr, flush, cam_dout, mem_ack,
        input  req_ready, resp_valid, resp_hit, resp_way,
               cam_rd_n, cam_we_n, cam_addrs, cam_din, mem_req, mem_addr
    );
endinterface

// File: rtl/lhn_cam_cache_ctrl.sv
// Lookup/fill sequencer for a 2-way tag CAM; valid and LRU bits live here, tags in the CAM.
// Define LHN_CAM_CTRL_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module lhn_cam_cache_ctrl #(
    parameter int unsigned TAG_W  = 9,
    parameter int unsigned SET_W  = 3,
    parameter int unsigned WORD_W = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    lhn_cam_cache_ctrl_if.master      bus
`ifdef LHN_CAM_CTRL_STATS_EN
    ,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
`endif
);
    localparam int unsigned NumSets = 1 << SET_W;
    localparam int unsigned AddrW   = TAG_W + SET_W + WORD_W;

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StCmp, StFill, StTwr, StResp} state_e;

    state_e                    state_q, state_d;
    logic [TAG_W-1:0]          tag_q, t0_q, t1_q;
    logic [SET_W-1:0]          set_q;
    logic [NumSets-1:0][1:0]   valid_q;
    logic [NumSets-1:0]        lru_q;
    logic                      hit_q, way_q, flush_pend_q;
    logic                      accept, flush_now, hit0, hit1, victim;
    logic                      unused_word;

    assign unused_word = ^bus.req_addr[WORD_W-1:0];
    assign accept      = bus.req_valid & bus.req_ready;
    assign flush_now   = (state_q == StIdle) & (bus.flush | flush_pend_q);
    assign hit0        = valid_q[set_q][0] & (t0_q == tag_q);
    assign hit1        = valid_q[set_q][1] & (t1_q == tag_q);
    // Fill empty ways first, otherwise the LRU bit names the way to replace.
    assign victim      = !valid_q[set_q][0] ? 1'b0 :
                         !valid_q[set_q][1] ? 1'b1 : lru_q[set_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRd0;
            StRd0:   state_d = StRd1;
            StRd1:   state_d = StCmp;
            StCmp:   state_d = (hit0 | hit1) ? StResp : StFill;
            StFill:  if (bus.mem_ack) state_d = StTwr;
            StTwr:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == StIdle) & ~flush_pend_q & ~bus.flush;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_way   = 1'b0;
        bus.cam_rd_n   = 1'b1;
        bus.cam_we_n   = 1'b1;
        bus.cam_addrs  = '0;
        bus.cam_din    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_addr   = '0;
        unique case (state_q)
            StRd0: begin
                bus.cam_rd_n  = 1'b0;
                bus.cam_addrs = {set_q, 1'b0};
            end
            StRd1: begin
                bus.cam_rd_n  = 1'b0;
                bus.cam_addrs = {set_q, 1'b1};
            end
            StFill: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag_q, set_q};
            end
            StTwr: begin
                bus.cam_we_n  = 1'b0;
                bus.cam_addrs = {set_q, way_q};
                bus.cam_din   = tag_q;
            end
            StResp: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit_q;
                bus.resp_way   = way_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q        <= '0;
            set_q        <= '0;
            t0_q         <= '0;
            t1_q         <= '0;
            hit_q        <= 1'b0;
            way_q        <= 1'b0;
            valid_q      <= '0;
            lru_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                tag_q <= bus.req_addr[AddrW-1 -: TAG_W];
                set_q <= bus.req_addr[SET_W+WORD_W-1 -: SET_W];
            end
            if (state_q == StRd0) t0_q <= bus.cam_dout;
            if (state_q == StRd1) t1_q <= bus.cam_dout;
            if (state_q == StCmp) begin
                hit_q <= hit0 | hit1;
                way_q <= (hit0 | hit1) ? ~hit0 : victim;
            end
            if (state_q == StTwr)  valid_q[set_q][way_q] <= 1'b1;
            if (state_q == StResp) lru_q[set_q] <= ~way_q;
            // A flush seen while busy waits for the next IDLE cycle.
            if (flush_now) begin
                valid_q      <= '0;
                lru_q        <= '0;
                flush_pend_q <= 1'b0;
            end else if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

`ifdef LHN_CAM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == StResp) begin
            if (hit_q) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_lhn_cam_cache_ctrl.sv
// Bench for lhn_cam_cache_ctrl: behavioural CAM + memory responder, scoreboard of expected responses.
module tb_lhn_cam_cache_ctrl;
    localparam int unsigned TAG_W  = 9;
    localparam int unsigned SET_W  = 3;
    localparam int unsigned WORD_W = 3;

    typedef struct {
        logic [14:0] addr;
        logic        hit;
        logic        way;
    } exp_t;

    typedef struct {
        logic [14:0] addr;
        logic        hit;
        logic        way;
        int          ack_delay;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0, accept_cyc = 0, ack_cyc = 0, mem_cyc = 0, wr_cyc = 0, resp_cnt = 0;
    exp_t sb[$];
    exp_t e_mon;
    vec_t vecs[10];
    bit   done;

    logic [TAG_W-1:0] cam [16] = '{default: '0};
    logic             poke_en   = 1'b0;
    logic [3:0]       poke_addr = '0;
    logic [TAG_W-1:0] poke_data = '0;

    always #5 clk = ~clk;

    lhn_cam_cache_ctrl_if #(.TAG_W(TAG_W), .SET_W(SET_W), .WORD_W(WORD_W)) bus ();

`ifdef LHN_CAM_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    lhn_cam_cache_ctrl #(.TAG_W(TAG_W), .SET_W(SET_W), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef LHN_CAM_CTRL_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    assign bus.cam_dout = cam[bus.cam_addrs];

    always @(posedge clk) begin
        if (poke_en) cam[poke_addr] <= poke_data;
        else if (!bus.cam_we_n) cam[bus.cam_addrs] <= bus.cam_din;
    end

    function automatic logic [14:0] mk(input logic [8:0] t, input logic [2:0] s, input logic [2:0] w);
        return {t, s, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each response.
    always @(negedge clk) begin
        logic [3:0] rd_exp;
        cyc++;
        if (bus.req_valid && bus.req_ready) begin
            accept_cyc = cyc;
            mem_cyc    = 0;
            wr_cyc     = 0;
            ack_cyc    = 0;
        end
        if (sb.size() != 0) begin
            if (!bus.cam_rd_n) begin
                rd_exp = {sb[0].addr[5:3], (cyc - accept_cyc == 2)};
                check("cam_rd_addr", 32'(bus.cam_addrs), 32'(rd_exp));
            end
            if (!bus.cam_we_n) begin
                wr_cyc++;
                check("rd_we_excl", 32'(bus.cam_rd_n), 1);
                check("cam_wr_addr", 32'(bus.cam_addrs), 32'({sb[0].addr[5:3], sb[0].way}));
                check("cam_din", 32'(bus.cam_din), 32'(sb[0].addr[14:6]));
            end
            if (bus.mem_req) begin
                mem_cyc++;
                check("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr[14:3]));
                if (bus.mem_ack) ack_cyc = cyc;
            end
        end
        if (bus.resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                check("resp_hit", 32'(bus.resp_hit), 32'(e_mon.hit));
                check("resp_way", 32'(bus.resp_way), 32'(e_mon.way));
                check("mem_used", 32'(mem_cyc != 0), 32'(!e_mon.hit));
                check("cam_writes", wr_cyc, e_mon.hit ? 0 : 1);
                if (e_mon.hit) check("hit_latency", cyc - accept_cyc, 4);
                else           check("miss_latency", cyc - ack_cyc, 2);
            end
            resp_cnt++;
        end
    end

    // Issue one lookup, answer its fetch after ack_delay FILL cycles; returns in the IDLE cycle after RESP.
    task automatic lookup(input logic [14:0] addr, input logic hit, input logic way,
                          input int ack_delay, input bit flush_in_fill);
        exp_t e;
        int   rc, n;
        bit   acked, got;
        e.addr = addr;
        e.hit  = hit;
        e.way  = way;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!got) begin
            check("accept_timeout", 0, 1);
            sb.delete();
            return;
        end
        rc    = resp_cnt;
        n     = 0;
        acked = 1'b0;
        for (int i = 0; i < 60 && resp_cnt == rc; i++) begin
            @(posedge clk); #2;
            bus.mem_ack = 1'b0;
            bus.flush   = 1'b0;
            if (bus.mem_req && !acked) begin
                if (flush_in_fill && n == 0) bus.flush = 1'b1;
                if (n >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    acked       = 1'b1;
                end
                n++;
            end
        end
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        if (resp_cnt == rc) begin
            check("resp_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;

        vecs[0] = '{15'h0A5F,            1'b0, 1'b0, 2};
        vecs[1] = '{15'h0A5F,            1'b1, 1'b0, 0};
        vecs[2] = '{mk(9'h033, 3, 1),    1'b0, 1'b1, 0};
        vecs[3] = '{mk(9'h040, 3, 2),    1'b0, 1'b0, 3};
        vecs[4] = '{mk(9'h033, 3, 0),    1'b1, 1'b1, 0};
        vecs[5] = '{mk(9'h051, 3, 5),    1'b0, 1'b0, 1};
        vecs[6] = '{mk(9'h051, 3, 3),    1'b1, 1'b0, 0};
        vecs[7] = '{mk(9'h029, 5, 0),    1'b0, 1'b0, 0};
        vecs[8] = '{mk(9'h033, 3, 7),    1'b1, 1'b1, 0};
        vecs[9] = '{mk(9'h029, 5, 6),    1'b1, 1'b0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_outs", 32'({bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_way,
                                    bus.cam_rd_n, bus.cam_we_n, bus.mem_req}), 32'b1000110);
        check("rst_bus_outs", 32'({bus.cam_addrs, bus.cam_din, bus.mem_addr}), 0);
`ifdef LHN_CAM_CTRL_STATS_EN
        check("rst_cnts", 32'({hit_cnt, miss_cnt}), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            lookup(vecs[i].addr, vecs[i].hit, vecs[i].way, vecs[i].ack_delay, 1'b0);
        end

        // Same tag in both ways of set 3: way 0 must win
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = 4'h7; poke_data = 9'h051;
        @(posedge clk); #1;
        poke_en = 1'b0;
        lookup(mk(9'h051, 3, 4), 1'b1, 1'b0, 0, 1'b0);

        // Flush in IDLE beats a simultaneous request and invalidates everything
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = mk(9'h051, 3, 0);
        @(negedge clk);
        check("flush_blocks_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        lookup(mk(9'h051, 3, 0), 1'b0, 1'b0, 0, 1'b0);
        lookup(mk(9'h029, 5, 0), 1'b0, 1'b0, 1, 1'b0);

        // Flush during FILL: fill completes, flush lands on the following IDLE cycle
        lookup(mk(9'h0AA, 1, 0), 1'b0, 1'b0, 2, 1'b1);
        check("flush_pend_ready", 32'(bus.req_ready), 0);
        lookup(mk(9'h0AA, 1, 1), 1'b0, 1'b0, 0, 1'b0);
        lookup(15'h0A5F,         1'b0, 1'b0, 0, 1'b0);

        // Stray mem_ack in IDLE
        @(posedge clk); #2;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_mem_req", 32'(bus.mem_req), 0);
        @(posedge clk); #2;
        bus.mem_ack = 1'b0;
        check("idle_ack_state", 32'({bus.req_ready, bus.cam_rd_n, bus.resp_valid}), 32'b110);

        // Reset while a fetch is outstanding
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = mk(9'h0BB, 2, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_req) done = 1'b1;
        end
        check("rst_mid_fill_reached", 32'(done), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_mem_req", 32'(bus.mem_req), 0);
        check("rst_mid_ready", 32'(bus.req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Previously valid lines miss after reset; 2 misses then 3 hits
        lookup(mk(9'h0AA, 1, 0), 1'b0, 1'b0, 1, 1'b0);
        lookup(mk(9'h029, 5, 0), 1'b0, 1'b0, 0, 1'b0);
        lookup(mk(9'h0AA, 1, 5), 1'b1, 1'b0, 0, 1'b0);
        lookup(mk(9'h029, 5, 1), 1'b1, 1'b0, 0, 1'b0);
        lookup(mk(9'h0AA, 1, 2), 1'b1, 1'b0, 0, 1'b0);
`ifdef LHN_CAM_CTRL_STATS_EN
        check("hit_cnt", 32'(hit_cnt), 3);
        check("miss_cnt", 32'(miss_cnt), 2);
`endif
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
